// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard-to-character-FIFO path.
// PS2_SHIFT_EN (optional define) enables shift-key handling in ps2_char_writer.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DECODE,
    WRITE
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] ASCII_NL   = 8'h0A;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] SHIFT_L    = 8'h12;
  localparam logic [7:0] SHIFT_R    = 8'h59;

  // Data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SHIFT_L) || (code == SHIFT_R);
  endfunction

  // Selects the shifted or unshifted form of a character.
  function automatic logic [7:0] pick(input logic shift, input logic [7:0] lower,
                                      input logic [7:0] upper);
    return shift ? upper : lower;
  endfunction

endpackage

// File: rtl/ps2_scancode_rom.sv
// Combinational set-2 scancode (+ shift) to ASCII lookup.
// valid=0 marks codes that produce no character.
module ps2_scancode_rom
  import ps2_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic       valid,
  output logic [7:0] ascii
);

  // Table lookup; anything not listed is unmapped.
  always_comb begin
    valid = 1'b1;
    ascii = '0;
    case (scancode)
      8'h1C: ascii = pick(shift, 8'h61, 8'h41); // a
      8'h32: ascii = pick(shift, 8'h62, 8'h42); // b
      8'h21: ascii = pick(shift, 8'h63, 8'h43); // c
      8'h23: ascii = pick(shift, 8'h64, 8'h44); // d
      8'h24: ascii = pick(shift, 8'h65, 8'h45); // e
      8'h2B: ascii = pick(shift, 8'h66, 8'h46); // f
      8'h34: ascii = pick(shift, 8'h67, 8'h47); // g
      8'h33: ascii = pick(shift, 8'h68, 8'h48); // h
      8'h43: ascii = pick(shift, 8'h69, 8'h49); // i
      8'h3B: ascii = pick(shift, 8'h6A, 8'h4A); // j
      8'h42: ascii = pick(shift, 8'h6B, 8'h4B); // k
      8'h4B: ascii = pick(shift, 8'h6C, 8'h4C); // l
      8'h3A: ascii = pick(shift, 8'h6D, 8'h4D); // m
      8'h31: ascii = pick(shift, 8'h6E, 8'h4E); // n
      8'h44: ascii = pick(shift, 8'h6F, 8'h4F); // o
      8'h4D: ascii = pick(shift, 8'h70, 8'h50); // p
      8'h15: ascii = pick(shift, 8'h71, 8'h51); // q
      8'h2D: ascii = pick(shift, 8'h72, 8'h52); // r
      8'h1B: ascii = pick(shift, 8'h73, 8'h53); // s
      8'h2C: ascii = pick(shift, 8'h74, 8'h54); // t
      8'h3C: ascii = pick(shift, 8'h75, 8'h55); // u
      8'h2A: ascii = pick(shift, 8'h76, 8'h56); // v
      8'h1D: ascii = pick(shift, 8'h77, 8'h57); // w
      8'h22: ascii = pick(shift, 8'h78, 8'h58); // x
      8'h35: ascii = pick(shift, 8'h79, 8'h59); // y
      8'h1A: ascii = pick(shift, 8'h7A, 8'h5A); // z
      8'h16: ascii = pick(shift, 8'h31, 8'h21); // 1 !
      8'h1E: ascii = pick(shift, 8'h32, 8'h40); // 2 @
      8'h26: ascii = pick(shift, 8'h33, 8'h23); // 3 #
      8'h25: ascii = pick(shift, 8'h34, 8'h24); // 4 $
      8'h2E: ascii = pick(shift, 8'h35, 8'h25); // 5 %
      8'h36: ascii = pick(shift, 8'h36, 8'h5E); // 6 ^
      8'h3D: ascii = pick(shift, 8'h37, 8'h26); // 7 &
      8'h3E: ascii = pick(shift, 8'h38, 8'h2A); // 8 *
      8'h46: ascii = pick(shift, 8'h39, 8'h28); // 9 (
      8'h45: ascii = pick(shift, 8'h30, 8'h29); // 0 )
      8'h29: ascii = ASCII_SP;
      8'h5A: ascii = ASCII_NL;
      8'h66: ascii = ASCII_BS;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_char_writer.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames
// 11-bit packets, tracks break/extended prefixes and writes ASCII into a FIFO.
// Define PS2_SHIFT_EN to track the shift keys and emit shifted characters.
module ps2_char_writer
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       fifo_full,
  output logic       fifo_write,
  output logic [7:0] data_to_fifo,
  output logic       frame_error,
  output logic       overflow
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          bit_in;

  state_t        state;
  state_t        state_next;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          in_frame;
  logic          timeout;
  logic          err;
  logic          ovf;
  logic          brk_flag;
  logic          ext_flag;
  logic          pend;
  logic [7:0]    char_q;
  logic [7:0]    last_char;
  logic          rom_shift;
  logic          rom_valid;
  logic [7:0]    rom_ascii;
`ifdef PS2_SHIFT_EN
  logic          shift_flag;
`endif

  // Two-flop synchronizers; idle level of both lines is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock only follows after FILTER_LEN equal samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign bit_in   = data_sync[1];
  assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);
  assign timeout  = in_frame && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_SHIFT_EN
  assign rom_shift = shift_flag;
`else
  assign rom_shift = 1'b0;
`endif

  ps2_scancode_rom u_rom (
    .scancode (shift_reg),
    .shift    (rom_shift),
    .valid    (rom_valid),
    .ascii    (rom_ascii)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus error, write and overflow strobes.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    ovf        = 1'b0;
    fifo_write = 1'b0;
    if (timeout) begin
      err        = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            if (!bit_in) state_next = DATA;
            else         err        = 1'b1;
          end
        end
        DATA: begin
          if (fall && (bit_cnt == 3'd7)) state_next = PARITY;
        end
        PARITY: begin
          if (fall) state_next = STOP;
        end
        STOP: begin
          if (fall) begin
            if (bit_in && odd_parity_ok(shift_reg, par_bit)) begin
              state_next = DECODE;
            end else begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        DECODE: state_next = WRITE;
        WRITE: begin
          fifo_write = pend & ~fifo_full;
          ovf        = pend & fifo_full;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame datapath: shifting, parity capture, timeout count and prefix flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
      pend      <= 1'b0;
      char_q    <= '0;
`ifdef PS2_SHIFT_EN
      shift_flag <= 1'b0;
`endif
    end else begin
      if (fall || !in_frame) to_cnt <= '0;
      else                   to_cnt <= to_cnt + TW'(1);

      if (err) begin
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
      end

      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          if (fall) begin
            shift_reg <= {bit_in, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (fall) par_bit <= bit_in;
        end
        DECODE: begin
          // Prefixes arm a flag; the next non-prefix code is swallowed and
          // disarms both flags, so E0 F0 xx releases an extended key cleanly.
          pend <= 1'b0;
          if (shift_reg == BREAK_CODE) begin
            brk_flag <= 1'b1;
          end else if (shift_reg == EXT_CODE) begin
            ext_flag <= 1'b1;
          end else if (brk_flag || ext_flag) begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
`ifdef PS2_SHIFT_EN
            if (brk_flag && is_shift_code(shift_reg)) shift_flag <= 1'b0;
`endif
          end
`ifdef PS2_SHIFT_EN
          else if (is_shift_code(shift_reg)) begin
            shift_flag <= 1'b1;
          end
`endif
          else begin
            pend   <= rom_valid;
            char_q <= rom_ascii;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status pulses and the held copy of the last written character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      last_char   <= '0;
    end else begin
      frame_error <= err;
      overflow    <= ovf;
      if (fifo_write) last_char <= char_q;
    end
  end

  // Present the fresh character during the strobe, otherwise hold the last one.
  always_comb begin
    data_to_fifo = last_char;
    if (fifo_write) data_to_fifo = char_q;
  end

endmodule

// File: doc/ps2_char_writer.md
PS2_CHAR_WRITER -- requirements
Module: ps2_char_writer

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples required before filtered ps2_clk changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: idle clock cycles mid-frame before the frame is aborted.
REQ-003 clock  input  1  single system clock, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to clock.
REQ-006 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to clock.
REQ-007 fifo_full  input  1  character FIFO cannot accept a write.
REQ-008 fifo_write  output  1  one-cycle write strobe into the character FIFO.
REQ-009 data_to_fifo  output  8  ASCII character or control code, valid while fifo_write=1.
REQ-010 frame_error  output  1  one-cycle pulse on start, parity or stop error, or timeout.
REQ-011 overflow  output  1  one-cycle pulse when a decoded character is dropped because fifo_full=1.

Function
REQ-012 ps2_clk and ps2_data SHALL pass a 2-flop synchronizer; ps2_clk SHALL then pass the FILTER_LEN glitch filter.
REQ-013 Bits SHALL be sampled on the filtered ps2_clk falling edge.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP, DECODE, WRITE.
- IDLE->DATA when sampled start bit is 0; if it is 1, pulse frame_error and stay in IDLE.
- DATA shifts in 8 bits, LSB first, then moves to PARITY.
- PARITY->STOP always; parity is checked at STOP.
- STOP->DECODE when stop bit is 1 and odd parity holds; otherwise pulse frame_error and go to IDLE.
- DECODE->WRITE after one cycle; WRITE->IDLE after one cycle.
REQ-015 Odd parity: data bits plus parity bit SHALL contain an odd number of ones.
REQ-016 fifo_write SHALL assert exactly 2 cycles after the cycle in which the stop-bit falling edge is detected.
REQ-017 fifo_write SHALL be a single-cycle pulse per character.
REQ-018 If fifo_full=1 in WRITE: no fifo_write, pulse overflow, drop the character; no retry.
REQ-019 Scancode 0xF0 (break prefix) SHALL set a break flag; the next code is consumed without a write and the flag is cleared.
REQ-020 Scancode 0xE0 (extended prefix) SHALL set an extended flag; the next code is consumed without a write and the flag is cleared.
REQ-021 Mapping (unshifted):
- Letters 0x1C..: a-z (0x61-0x7A).
- Digits: 0x16..0x45 -> 0x31-0x39, 0x30.
- 0x29 -> 0x20 (space).
- 0x5A -> 0x0A (newline, consumed by the LCD side as a line break).
- 0x66 -> 0x08 (backspace).
REQ-022 Unmapped codes SHALL produce no write and no error.
REQ-023 A frame error or timeout SHALL clear the break and extended flags.
REQ-024 If no filtered falling edge arrives for TIMEOUT_CYCLES in any state other than IDLE, the FSM SHALL pulse frame_error and return to IDLE.
REQ-025 data_to_fifo SHALL hold its last value between writes.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE and clear the shift register, bit counter, timeout counter, all flags and the filter state.
REQ-027 On reset, fifo_write, frame_error, overflow = 0 and data_to_fifo = 0x00.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next frame starts from a clean IDLE.

Configuration
REQ-029 With PS2_SHIFT_EN defined:
- 0x12 and 0x59 make codes set the shift flag; their break codes clear it.
- While shift is set, letters map to 0x41-0x5A and digits 1-0 map to !@#$%^&*().
REQ-030 Without PS2_SHIFT_EN: shift codes are treated as unmapped and only unshifted output is produced.

Structure
REQ-031 Package ps2_pkg SHALL hold the state encoding and the constants BREAK_CODE=0xF0, EXT_CODE=0xE0, ASCII_NL=0x0A and ASCII_BS=0x08.
REQ-032 Sub-module ps2_scancode_rom SHALL be a combinational scancode+shift -> {valid, ascii} lookup.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Frame 0x1C, parity bit 0 -> one fifo_write with data_to_fifo=0x61; frame_error stays 0.
- Frames 0xF0 then 0x1C -> no fifo_write.
- Frame 0x1C with parity bit 1 -> one frame_error pulse, no fifo_write; the following valid 0x29 frame writes 0x20.
- fifo_full=1, frame 0x5A -> no fifo_write, one overflow pulse; fifo_full=0, frame 0x66 -> writes 0x08.
- Frames 0x12, 0x1C, 0xF0, 0x12, 0x1C -> writes 0x41 then 0x61 with PS2_SHIFT_EN; 0x61 then 0x61 without.
- Reset asserted after 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 -> all outputs 0; the next frame 0x16 writes 0x31.
